// File: rtl/pll_lock_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_seq
//  Description : Reset/lock sequencer for the HDMI system PLL. Holds the PLL
//                in reset, waits for its extlock output, qualifies lock over a
//                stability window and only then releases the downstream
//                active-low system reset. Lock loss or lock timeout re-runs
//                the sequence; too many failed attempts park the block in a
//                sticky FAULT state until rst_n.
//                Clocked from the free-running board reference clock, never
//                from a PLL output clock.
//  Ports       : clk        in   reference clock (same source as PLL refclk)
//                rst_n      in   asynchronous active-low reset
//                extlock    in   PLL lock indication, asynchronous to clk
//                pll_reset  out  active-high reset to the PLL
//                sys_rst_n  out  active-low reset for PLL-clocked logic
//                locked     out  high only while running with a good lock
//                retry_cnt  out  failed attempts since rst_n, saturates at 15
//                fault      out  sticky fault flag
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_seq #(
    parameter int RST_HOLD     = 16,     // cycles pll_reset is held per attempt
    parameter int LOCK_STABLE  = 1024,   // consecutive lock cycles before release
    parameter int LOCK_TIMEOUT = 65536,  // cycles allowed waiting for lock
    parameter int MAX_RETRY    = 7       // failed attempts before FAULT, 0 = never
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       extlock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic [3:0] retry_cnt,
    output logic       fault
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [c_cnt_w-1:0] c_rst_hold_last = c_cnt_w'(RST_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last   = c_cnt_w'(LOCK_STABLE - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last  = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one       = c_cnt_w'(1);

    localparam logic [3:0] c_max_retry     = 4'(MAX_RETRY);
    localparam logic [3:0] c_retry_sat     = 4'hF;
    localparam bit         c_retry_limited = (MAX_RETRY != 0);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic               r_sync_meta;
    logic               r_lock_s;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [3:0]         r_retry;
    logic               r_pll_reset;
    logic               r_sys_rst_n;
    logic               r_locked;
    logic               r_fault;

    state_t             w_state_nxt;
    logic               w_fail;
    logic [3:0]         w_retry_inc;
    logic               w_cnt_active;

    // ------------------------------------------------------------------------
    // extlock synchroniser. Everything downstream looks only at r_lock_s, so
    // a lock edge takes two clocks to become visible to the sequencer.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= extlock;
            r_lock_s    <= r_sync_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fail      = 1'b0;
        w_retry_inc = (r_retry == c_retry_sat) ? c_retry_sat : (r_retry + 4'd1);

        case (r_state)
            ST_RST_PLL: begin
                if (r_cnt == c_rst_hold_last) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock seen wins over a timeout landing on the same cycle.
                if (r_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == c_timeout_last) begin
                    w_fail = 1'b1;
                end
            end
            ST_STABLE: begin
                // A dropout inside the window is not charged as a retry; the
                // PLL simply goes back to waiting with a fresh timeout.
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Losing lock while running is charged, so a PLL that keeps
                // dropping out ends up in FAULT rather than cycling forever.
                if (!r_lock_s) begin
                    w_fail = 1'b1;
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_RST_PLL;
            end
        endcase

        if (w_fail) begin
            if (c_retry_limited && (w_retry_inc >= c_max_retry)) begin
                w_state_nxt = ST_FAULT;
            end else begin
                w_state_nxt = ST_RST_PLL;
            end
        end
    end

    // Only the timed states need the counter; it idles at zero elsewhere.
    assign w_cnt_active = (r_state == ST_RST_PLL)   ||
                          (r_state == ST_WAIT_LOCK) ||
                          (r_state == ST_STABLE);

    // ------------------------------------------------------------------------
    // State, counter and retry registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST_PLL;
            r_cnt   <= '0;
            r_retry <= 4'd0;
        end else begin
            r_state <= w_state_nxt;

            // The counter restarts on every state change, so each state's
            // timing is measured from its own entry.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_active) begin
                r_cnt <= r_cnt + c_cnt_one;
            end

            if (w_fail) begin
                r_retry <= w_retry_inc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs, decoded from the current state. This puts one clock
    // between a state change and the pins: sys_rst_n/locked rise the cycle
    // after RUN is entered and fall the cycle after RUN is left, which keeps
    // the outputs glitch-free for the PLL and the downstream reset trees.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_pll_reset <= (r_state == ST_RST_PLL) || (r_state == ST_FAULT);
            r_sys_rst_n <= (r_state == ST_RUN);
            r_locked    <= (r_state == ST_RUN);
            r_fault     <= (r_state == ST_FAULT);
        end
    end

    assign pll_reset = r_pll_reset;
    assign sys_rst_n = r_sys_rst_n;
    assign locked    = r_locked;
    assign retry_cnt = r_retry;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_lock_seq
//  Description : Self-checking bench for pll_lock_seq. Two instances share
//                all inputs: dut_a with a finite retry limit and dut_b with
//                MAX_RETRY=0. An extlock waveform is written into lk[], played
//                cycle by cycle, and each recorded output trace is compared
//                with the trace predicted by an interval-level reference
//                model of the lock sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_seq;

    localparam int RH = 4;    // RST_HOLD
    localparam int LS = 20;   // LOCK_STABLE
    localparam int LT = 64;   // LOCK_TIMEOUT
    localparam int MR = 3;    // MAX_RETRY of dut_a
    localparam int N  = 2048;

    localparam int P_RST   = 0;
    localparam int P_WAIT  = 1;
    localparam int P_STB   = 2;
    localparam int P_RUN   = 3;
    localparam int P_FAULT = 4;
    localparam int P_FAIL  = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       extlock = 1'b0;
    logic       pll_reset_a, sys_rst_n_a, locked_a, fault_a;
    logic [3:0] retry_cnt_a;
    logic       pll_reset_b, sys_rst_n_b, locked_b, fault_b;
    logic [3:0] retry_cnt_b;

    always #5 clk = ~clk;

    pll_lock_seq #(.RST_HOLD(RH), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRY(MR)) dut_a (
        .clk(clk), .rst_n(rst_n), .extlock(extlock),
        .pll_reset(pll_reset_a), .sys_rst_n(sys_rst_n_a), .locked(locked_a),
        .retry_cnt(retry_cnt_a), .fault(fault_a)
    );

    pll_lock_seq #(.RST_HOLD(RH), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .extlock(extlock),
        .pll_reset(pll_reset_b), .sys_rst_n(sys_rst_n_b), .locked(locked_b),
        .retry_cnt(retry_cnt_b), .fault(fault_b)
    );

    bit         lk   [N];           // extlock value sampled at clock edge e
    logic [3:0] rec  [2][5][N];     // observed: [dut][signal][edge]
    logic [3:0] expv [2][5][N];     // predicted
    int         n_checks = 0;
    int         n_pass   = 0;

    function automatic string sname(input int s);
        case (s)
            0:       return "pll_reset";
            1:       return "sys_rst_n";
            2:       return "locked";
            3:       return "retry_cnt";
            default: return "fault";
        endcase
    endfunction

    // Lock level the sequencer acts on at edge e (two-flop synchroniser).
    function automatic bit ls(input int e);
        if (e < 3 || e - 2 >= N) return 1'b0;
        return lk[e - 2];
    endfunction

    // Walk the sequence phase by phase: each phase lasts until the first edge
    // at which its exit rule fires. Outputs lag the phase by one edge.
    task automatic build_model(input int d, input int mr, input int len);
        int ph [N];
        int rc [N];
        int cur, nxt, phs, nph, rt;
        rt  = 0;
        cur = 0;
        phs = P_RST;
        while (cur <= len) begin
            nxt = len + 1;
            nph = phs;
            case (phs)
                P_RST: begin
                    nxt = cur + RH;
                    nph = P_WAIT;
                end
                P_WAIT: begin
                    nxt = cur + LT;
                    nph = P_FAIL;
                    for (int k = LT; k >= 1; k--)
                        if (ls(cur + k)) begin nxt = cur + k; nph = P_STB; end
                end
                P_STB: begin
                    nxt = cur + LS;
                    nph = P_RUN;
                    for (int k = LS; k >= 1; k--)
                        if (!ls(cur + k)) begin nxt = cur + k; nph = P_WAIT; end
                end
                P_RUN: begin
                    for (int k = len - cur + 1; k >= 1; k--)
                        if (!ls(cur + k)) begin nxt = cur + k; nph = P_FAIL; end
                end
                default: ;
            endcase
            for (int i = cur; i < nxt && i <= len; i++) begin
                ph[i] = phs;
                rc[i] = rt;
            end
            if (nph == P_FAIL) begin
                rt  = (rt < 15) ? rt + 1 : 15;
                nph = (mr != 0 && rt >= mr) ? P_FAULT : P_RST;
            end
            cur = nxt;
            phs = nph;
        end
        expv[d][0][0] = 4'd1;
        expv[d][1][0] = 4'd0;
        expv[d][2][0] = 4'd0;
        expv[d][3][0] = 4'd0;
        expv[d][4][0] = 4'd0;
        for (int e = 1; e <= len; e++) begin
            expv[d][0][e] = 4'((ph[e-1] == P_RST) || (ph[e-1] == P_FAULT));
            expv[d][1][e] = 4'(ph[e-1] == P_RUN);
            expv[d][2][e] = 4'(ph[e-1] == P_RUN);
            expv[d][3][e] = 4'(rc[e]);
            expv[d][4][e] = 4'(ph[e-1] == P_FAULT);
        end
    endtask

    task automatic record(input int e);
        rec[0][0][e] = 4'(pll_reset_a);
        rec[0][1][e] = 4'(sys_rst_n_a);
        rec[0][2][e] = 4'(locked_a);
        rec[0][3][e] = retry_cnt_a;
        rec[0][4][e] = 4'(fault_a);
        rec[1][0][e] = 4'(pll_reset_b);
        rec[1][1][e] = 4'(sys_rst_n_b);
        rec[1][2][e] = 4'(locked_b);
        rec[1][3][e] = retry_cnt_b;
        rec[1][4][e] = 4'(fault_b);
    endtask

    // Reset both DUTs, then play lk[1..len] and record outputs after each edge.
    task automatic play(input int len);
        extlock = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        extlock = lk[1];
        #1 record(0);
        for (int e = 1; e <= len; e++) begin
            @(posedge clk);
            #1;
            record(e);
            extlock = (e + 1 < N) ? lk[e + 1] : 1'b0;
        end
        build_model(0, MR, len);
        build_model(1, 0, len);
    endtask

    function automatic int first_diff(input int d, input int s, input int len);
        for (int e = 0; e <= len; e++)
            if (rec[d][s][e] !== expv[d][s][e]) return e;
        return -1;
    endfunction

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n   = 1'b0;
        extlock = 1'($urandom_range(0, 1));
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({pll_reset_a, sys_rst_n_a, locked_a, retry_cnt_a, fault_a} !== 8'b1000_0000)
            $display("FAIL reset_a: got %b expected 10000000",
                     {pll_reset_a, sys_rst_n_a, locked_a, retry_cnt_a, fault_a});
        else n_pass++;
        n_checks++;
        if ({pll_reset_b, sys_rst_n_b, locked_b, retry_cnt_b, fault_b} !== 8'b1000_0000)
            $display("FAIL reset_b: got %b expected 10000000",
                     {pll_reset_b, sys_rst_n_b, locked_b, retry_cnt_b, fault_b});
        else n_pass++;
    endtask

    task automatic test_lock_from_start();
        int len, idx;
        len = RH + LS + 40;
        for (int i = 0; i < N; i++) lk[i] = 1'b1;
        play(len);
        for (int d = 0; d < 2; d++) for (int s = 0; s < 5; s++) begin
            idx = first_diff(d, s, len);
            n_checks++;
            if (idx < 0) n_pass++;
            else $display("FAIL lock_start dut%0d %s @%0d: got %0h expected %0h",
                          d, sname(s), idx, rec[d][s][idx], expv[d][s][idx]);
        end
        n_checks++;
        if (rec[0][1][RH+LS+1] !== 4'd0 || rec[0][1][RH+LS+2] !== 4'd1)
            $display("FAIL release_time: got %0h,%0h expected 0,1",
                     rec[0][1][RH+LS+1], rec[0][1][RH+LS+2]);
        else n_pass++;
        n_checks++;
        if (rec[0][0][RH] !== 4'd1 || rec[0][0][RH+1] !== 4'd0)
            $display("FAIL pll_reset_hold: got %0h,%0h expected 1,0",
                     rec[0][0][RH], rec[0][0][RH+1]);
        else n_pass++;
    endtask

    task automatic test_timeout_fault();
        int len, idx, tf;
        tf  = MR * (RH + LT);
        len = tf + 40;
        for (int i = 0; i < N; i++) lk[i] = 1'b0;
        play(len);
        for (int d = 0; d < 2; d++) for (int s = 0; s < 5; s++) begin
            idx = first_diff(d, s, len);
            n_checks++;
            if (idx < 0) n_pass++;
            else $display("FAIL timeout dut%0d %s @%0d: got %0h expected %0h",
                          d, sname(s), idx, rec[d][s][idx], expv[d][s][idx]);
        end
        n_checks++;
        if (rec[0][4][tf] !== 4'd0 || rec[0][4][tf+1] !== 4'd1)
            $display("FAIL fault_time: got %0h,%0h expected 0,1", rec[0][4][tf], rec[0][4][tf+1]);
        else n_pass++;
        n_checks++;
        if (rec[0][4][len] !== 4'd1 || rec[0][0][len] !== 4'd1 || rec[0][3][len] !== 4'(MR))
            $display("FAIL fault_hold: got fault=%0h pll_reset=%0h retry=%0h expected 1,1,%0d",
                     rec[0][4][len], rec[0][0][len], rec[0][3][len], MR);
        else n_pass++;
    endtask

    task automatic test_stable_glitch();
        int len, idx, g, gl;
        for (int it = 0; it < 3; it++) begin
            g   = RH + int'($urandom_range(2, LS - 3));
            gl  = int'($urandom_range(1, 3));
            len = g + gl + LS + 30;
            for (int i = 0; i < N; i++) lk[i] = (i >= g && i < g + gl) ? 1'b0 : 1'b1;
            play(len);
            for (int d = 0; d < 2; d++) for (int s = 0; s < 5; s++) begin
                idx = first_diff(d, s, len);
                n_checks++;
                if (idx < 0) n_pass++;
                else $display("FAIL stable_glitch g=%0d dut%0d %s @%0d: got %0h expected %0h",
                              g, d, sname(s), idx, rec[d][s][idx], expv[d][s][idx]);
            end
            n_checks++;
            if (rec[0][1][g+gl+LS+2] !== 4'd0 || rec[0][1][g+gl+LS+3] !== 4'd1 || rec[0][3][len] !== 4'd0)
                $display("FAIL window_restart g=%0d: got %0h,%0h retry=%0h expected 0,1 retry=0",
                         g, rec[0][1][g+gl+LS+2], rec[0][1][g+gl+LS+3], rec[0][3][len]);
            else n_pass++;
        end
    endtask

    task automatic test_run_drop();
        int len, idx, dp, dl, width;
        for (int it = 0; it < 2; it++) begin
            dp  = RH + LS + 5 + int'($urandom_range(0, 10));
            dl  = int'($urandom_range(1, 6));
            len = dp + dl + RH + LS + 40;
            for (int i = 0; i < N; i++) lk[i] = (i >= dp && i < dp + dl) ? 1'b0 : 1'b1;
            play(len);
            for (int d = 0; d < 2; d++) for (int s = 0; s < 5; s++) begin
                idx = first_diff(d, s, len);
                n_checks++;
                if (idx < 0) n_pass++;
                else $display("FAIL run_drop dut%0d %s @%0d: got %0h expected %0h",
                              d, sname(s), idx, rec[d][s][idx], expv[d][s][idx]);
            end
            n_checks++;
            if (rec[0][1][dp+2] !== 4'd1 || rec[0][1][dp+3] !== 4'd0)
                $display("FAIL drop_latency: got %0h,%0h expected 1,0", rec[0][1][dp+2], rec[0][1][dp+3]);
            else n_pass++;
            width = 0;
            for (int e = dp; e <= dp + RH + 10; e++) if (rec[0][0][e] === 4'd1) width++;
            n_checks++;
            if (width !== RH) $display("FAIL pll_pulse_width: got %0d expected %0d", width, RH);
            else n_pass++;
            n_checks++;
            if (rec[0][3][len] !== 4'd1 || rec[0][1][len] !== 4'd1)
                $display("FAIL relock: got retry=%0h sys_rst_n=%0h expected 1,1",
                         rec[0][3][len], rec[0][1][len]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int len, idx, pos, sl;
        bit v;
        len = 1200;
        for (int it = 0; it < 3; it++) begin
            pos = 1;
            v   = 1'($urandom_range(0, 1));
            lk[0] = 1'b0;
            while (pos < N) begin
                sl = int'($urandom_range(1, 90));
                for (int j = 0; j < sl && pos < N; j++) begin
                    lk[pos] = v;
                    pos++;
                end
                v = !v;
            end
            play(len);
            for (int d = 0; d < 2; d++) for (int s = 0; s < 5; s++) begin
                idx = first_diff(d, s, len);
                n_checks++;
                if (idx < 0) n_pass++;
                else $display("FAIL random%0d dut%0d %s @%0d: got %0h expected %0h",
                              it, d, sname(s), idx, rec[d][s][idx], expv[d][s][idx]);
            end
        end
    endtask

    task automatic test_forever_retry();
        int len, idx, rises;
        len = 20 * (RH + LT) + 20;
        for (int i = 0; i < N; i++) lk[i] = 1'b0;
        play(len);
        for (int s = 0; s < 5; s++) begin
            idx = first_diff(1, s, len);
            n_checks++;
            if (idx < 0) n_pass++;
            else $display("FAIL forever dut1 %s @%0d: got %0h expected %0h",
                          sname(s), idx, rec[1][s][idx], expv[1][s][idx]);
        end
        n_checks++;
        if (rec[1][3][len] !== 4'd15 || rec[1][4][len] !== 4'd0)
            $display("FAIL retry_saturate: got retry=%0h fault=%0h expected f,0",
                     rec[1][3][len], rec[1][4][len]);
        else n_pass++;
        rises = 0;
        for (int e = len - 3 * (RH + LT); e <= len; e++)
            if (rec[1][0][e] === 4'd1 && rec[1][0][e-1] === 4'd0) rises++;
        n_checks++;
        if (rises < 2) $display("FAIL pll_keeps_pulsing: got %0d pulses expected >=2", rises);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int len, idx;
        // In STABLE: pll_reset is low, so an immediate rise proves async reset.
        for (int i = 0; i < N; i++) lk[i] = 1'b1;
        play(RH + 6);
        n_checks++;
        if (pll_reset_a !== 1'b0) $display("FAIL stable_pre: got pll_reset=%b expected 0", pll_reset_a);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pll_reset_a, sys_rst_n_a, locked_a, retry_cnt_a, fault_a} !== 8'b1000_0000)
            $display("FAIL async_stable: got %b expected 10000000",
                     {pll_reset_a, sys_rst_n_a, locked_a, retry_cnt_a, fault_a});
        else n_pass++;

        // In FAULT: fault and retry_cnt must clear without a clock edge.
        for (int i = 0; i < N; i++) lk[i] = 1'b0;
        play(MR * (RH + LT) + 10);
        n_checks++;
        if (fault_a !== 1'b1) $display("FAIL fault_pre: got fault=%b expected 1", fault_a);
        else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pll_reset_a, sys_rst_n_a, locked_a, retry_cnt_a, fault_a} !== 8'b1000_0000)
            $display("FAIL async_fault_a: got %b expected 10000000",
                     {pll_reset_a, sys_rst_n_a, locked_a, retry_cnt_a, fault_a});
        else n_pass++;
        n_checks++;
        if ({pll_reset_b, sys_rst_n_b, locked_b, retry_cnt_b, fault_b} !== 8'b1000_0000)
            $display("FAIL async_fault_b: got %b expected 10000000",
                     {pll_reset_b, sys_rst_n_b, locked_b, retry_cnt_b, fault_b});
        else n_pass++;

        // Sequence restarts cleanly after the fault is cleared.
        len = RH + LS + 30;
        for (int i = 0; i < N; i++) lk[i] = 1'b1;
        play(len);
        for (int s = 0; s < 5; s++) begin
            idx = first_diff(0, s, len);
            n_checks++;
            if (idx < 0) n_pass++;
            else $display("FAIL restart dut0 %s @%0d: got %0h expected %0h",
                          sname(s), idx, rec[0][s][idx], expv[0][s][idx]);
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_lock_from_start();
        test_timeout_fault();
        test_stable_glitch();
        test_run_drop();
        test_random();
        test_forever_retry();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
